dcache_ctrl: RTL and testbench

//  Sequencer for the write-through, no-write-allocate dcache array. Serves LSQ loads and stores.

---
 rtl/dcache_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Data-cache sequencer: hit/miss handling for LSQ loads, blocking refill,
// and a write-through store buffer sharing the single memory port.
module dcache_ctrl #(
    parameter int SB_DEPTH = 4,
    parameter int IDX_W    = 4,
    parameter int TAG_W    = 25
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             lsq_ld_valid,
    input  logic [31:0]      lsq_ld_addr,
    output logic             lsq_ld_ready,
    output logic             ld_resp_valid,
    output logic [63:0]      ld_resp_data,
    input  logic             lsq_st_valid,
    input  logic [31:0]      lsq_st_addr,
    input  logic [31:0]      lsq_st_data,
    input  logic [2:0]       lsq_st_size,
    output logic             lsq_st_ready,
    output logic             dc_rd_en,
    output logic [IDX_W-1:0] dc_rd_idx,
    output logic [TAG_W-1:0] dc_rd_tag,
    input  logic             dc_rd_hit,
    input  logic [63:0]      dc_rd_data,
    output logic             dc_wr_en_mem,
    output logic             dc_wr_en_lsq,
    output logic [IDX_W-1:0] dc_wr_idx,
    output logic [TAG_W-1:0] dc_wr_tag,
    output logic [63:0]      dc_wr_data,
    output logic [2:0]       dc_size,
    output logic             dc_offset,
    output logic [1:0]       proc2mem_command,
    output logic [31:0]      proc2mem_addr,
    output logic [63:0]      proc2mem_data,
    output logic [2:0]       proc2mem_size,
    input  logic [3:0]       mem2proc_response,
    input  logic [63:0]      mem2proc_data,
    input  logic [3:0]       mem2proc_tag
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam logic [PTR_W:0] SB_FULL = SB_DEPTH[PTR_W:0];
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [2:0] SZ_DOUBLE = 3'd3;

    typedef enum logic [1:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        LD_FILL
    } state_t;

    state_t           state;
    logic [31:3]      ld_addr;
    logic [3:0]       saved_tag;
    logic [63:0]      fill_data;

    logic [31:0]      sb_addr [SB_DEPTH];
    logic [31:0]      sb_data [SB_DEPTH];
    logic [2:0]       sb_size [SB_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic ld_fire;
    logic st_fire;
    logic sb_drain;
    logic sb_pop;
    logic ld_issue;
    logic unused_bits;

    assign unused_bits  = ^lsq_ld_addr[2:0];

    assign lsq_ld_ready = (state == IDLE);
    assign lsq_st_ready = (count != SB_FULL) && (state != LD_FILL);
    assign ld_fire      = lsq_ld_valid && lsq_ld_ready;
    assign st_fire      = lsq_st_valid && lsq_st_ready;

    // Stores drain only before a miss is on the bus, keeping load/store order.
    assign sb_drain = (count != '0) && (state == IDLE || state == LD_REQ);
    assign sb_pop   = sb_drain && (mem2proc_response != 4'd0);
    assign ld_issue = (state == LD_REQ) && (count == '0);

    always_comb begin
        dc_rd_en      = ld_fire;
        dc_rd_idx     = '0;
        dc_rd_tag     = '0;
        ld_resp_valid = 1'b0;
        ld_resp_data  = '0;
        if (ld_fire) begin
            dc_rd_idx = lsq_ld_addr[IDX_W+2:3];
            dc_rd_tag = lsq_ld_addr[TAG_W+IDX_W+2:IDX_W+3];
        end
        if (state == LD_FILL) begin
            ld_resp_valid = 1'b1;
            ld_resp_data  = fill_data;
        end else if (ld_fire && dc_rd_hit) begin
            ld_resp_valid = 1'b1;
            ld_resp_data  = dc_rd_data;
        end
    end

    // Refill and store-hit writes never overlap: stores stall in LD_FILL.
    always_comb begin
        dc_wr_en_mem = 1'b0;
        dc_wr_en_lsq = 1'b0;
        dc_wr_idx    = '0;
        dc_wr_tag    = '0;
        dc_wr_data   = '0;
        dc_size      = '0;
        dc_offset    = 1'b0;
        if (state == LD_FILL) begin
            dc_wr_en_mem = 1'b1;
            dc_wr_idx    = ld_addr[IDX_W+2:3];
            dc_wr_tag    = ld_addr[TAG_W+IDX_W+2:IDX_W+3];
            dc_wr_data   = fill_data;
        end else if (st_fire) begin
            dc_wr_en_lsq = 1'b1;
            dc_wr_idx    = lsq_st_addr[IDX_W+2:3];
            dc_wr_tag    = lsq_st_addr[TAG_W+IDX_W+2:IDX_W+3];
            dc_wr_data   = {32'b0, lsq_st_data};
            dc_size      = lsq_st_size;
            dc_offset    = lsq_st_addr[2];
        end
    end

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        proc2mem_size    = '0;
        if (sb_drain) begin
            proc2mem_command = BUS_STORE;
            proc2mem_addr    = sb_addr[head];
            proc2mem_data    = {32'b0, sb_data[head]};
            proc2mem_size    = sb_size[head];
        end else if (ld_issue) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = {ld_addr, 3'b0};
            proc2mem_size    = SZ_DOUBLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            ld_addr   <= '0;
            saved_tag <= '0;
            fill_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ld_fire && !dc_rd_hit) begin
                        ld_addr <= lsq_ld_addr[31:3];
                        state   <= LD_REQ;
                    end
                end
                LD_REQ: begin
                    if (ld_issue && mem2proc_response != 4'd0) begin
                        saved_tag <= mem2proc_response;
                        state     <= LD_WAIT;
                    end
                end
                LD_WAIT: begin
                    if (saved_tag != 4'd0 && mem2proc_tag == saved_tag) begin
                        fill_data <= mem2proc_data;
                        state     <= LD_FILL;
                    end
                end
                LD_FILL: begin
                    saved_tag <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (st_fire) tail <= tail + 1'b1;
            if (sb_pop)  head <= head + 1'b1;
            unique case ({st_fire, sb_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (st_fire) begin
            sb_addr[tail] <= lsq_st_addr;
            sb_data[tail] <= lsq_st_data;
            sb_size[tail] <= lsq_st_size;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: hits, refill, store buffer, ordering,
// refill/store port conflict and reset during an outstanding miss.
module tb_dcache_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        lsq_ld_valid;
    logic [31:0] lsq_ld_addr;
    logic        lsq_ld_ready;
    logic        ld_resp_valid;
    logic [63:0] ld_resp_data;
    logic        lsq_st_valid;
    logic [31:0] lsq_st_addr;
    logic [31:0] lsq_st_data;
    logic [2:0]  lsq_st_size;
    logic        lsq_st_ready;
    logic        dc_rd_en;
    logic [3:0]  dc_rd_idx;
    logic [24:0] dc_rd_tag;
    logic        dc_rd_hit;
    logic [63:0] dc_rd_data;
    logic        dc_wr_en_mem;
    logic        dc_wr_en_lsq;
    logic [3:0]  dc_wr_idx;
    logic [24:0] dc_wr_tag;
    logic [63:0] dc_wr_data;
    logic [2:0]  dc_size;
    logic        dc_offset;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [2:0]  proc2mem_size;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    int checks = 0;
    int errors = 0;

    dcache_ctrl dut (
        .clock(clock),
        .reset(reset),
        .lsq_ld_valid(lsq_ld_valid),
        .lsq_ld_addr(lsq_ld_addr),
        .lsq_ld_ready(lsq_ld_ready),
        .ld_resp_valid(ld_resp_valid),
        .ld_resp_data(ld_resp_data),
        .lsq_st_valid(lsq_st_valid),
        .lsq_st_addr(lsq_st_addr),
        .lsq_st_data(lsq_st_data),
        .lsq_st_size(lsq_st_size),
        .lsq_st_ready(lsq_st_ready),
        .dc_rd_en(dc_rd_en),
        .dc_rd_idx(dc_rd_idx),
        .dc_rd_tag(dc_rd_tag),
        .dc_rd_hit(dc_rd_hit),
        .dc_rd_data(dc_rd_data),
        .dc_wr_en_mem(dc_wr_en_mem),
        .dc_wr_en_lsq(dc_wr_en_lsq),
        .dc_wr_idx(dc_wr_idx),
        .dc_wr_tag(dc_wr_tag),
        .dc_wr_data(dc_wr_data),
        .dc_size(dc_size),
        .dc_offset(dc_offset),
        .proc2mem_command(proc2mem_command),
        .proc2mem_addr(proc2mem_addr),
        .proc2mem_data(proc2mem_data),
        .proc2mem_size(proc2mem_size),
        .mem2proc_response(mem2proc_response),
        .mem2proc_data(mem2proc_data),
        .mem2proc_tag(mem2proc_tag)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [3:0] resp_seq [3];

    initial begin
        resp_seq[0] = 4'd0;
        resp_seq[1] = 4'd0;
        resp_seq[2] = 4'd3;
        reset = 1'b1;
        lsq_ld_valid = 1'b0;
        lsq_ld_addr = '0;
        lsq_st_valid = 1'b0;
        lsq_st_addr = '0;
        lsq_st_data = '0;
        lsq_st_size = '0;
        dc_rd_hit = 1'b0;
        dc_rd_data = '0;
        mem2proc_response = '0;
        mem2proc_data = '0;
        mem2proc_tag = '0;

        @(negedge clock);
        @(negedge clock);
        #1;
        check("rst_ld_ready", lsq_ld_ready, 1);
        check("rst_st_ready", lsq_st_ready, 1);
        check("rst_cmd", proc2mem_command, 0);
        check("rst_resp_v", ld_resp_valid, 0);
        check("rst_wr_mem", dc_wr_en_mem, 0);
        check("rst_rd_en", dc_rd_en, 0);
        @(negedge clock);
        reset = 1'b0;

        // load hit returns in the same cycle
        @(negedge clock);
        lsq_ld_valid = 1'b1;
        lsq_ld_addr = 32'h100;
        dc_rd_hit = 1'b1;
        dc_rd_data = 64'hAB;
        #1;
        check("hit_rd_en", dc_rd_en, 1);
        check("hit_idx", dc_rd_idx, 0);
        check("hit_tag", dc_rd_tag, 2);
        check("hit_resp_v", ld_resp_valid, 1);
        check("hit_resp_d", ld_resp_data, 64'hAB);
        check("hit_cmd", proc2mem_command, 0);

        // load miss with retried bus request
        @(negedge clock);
        lsq_ld_addr = 32'h200;
        dc_rd_hit = 1'b0;
        dc_rd_data = '0;
        #1;
        check("miss_resp_v", ld_resp_valid, 0);
        check("miss_tag", dc_rd_tag, 4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            lsq_ld_valid = 1'b0;
            mem2proc_response = resp_seq[i];
            #1;
            check("req_cmd", proc2mem_command, 1);
            check("req_addr", proc2mem_addr, 32'h200);
            check("req_size", proc2mem_size, 3);
            check("req_ld_ready", lsq_ld_ready, 0);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            mem2proc_response = 4'd0;
            mem2proc_tag = (i == 2) ? 4'd5 : 4'd0;
            #1;
            check("wait_cmd", proc2mem_command, 0);
            check("wait_resp_v", ld_resp_valid, 0);
        end
        @(negedge clock);
        mem2proc_tag = 4'd3;
        mem2proc_data = 64'h55;
        #1;
        check("tag_resp_v", ld_resp_valid, 0);
        @(negedge clock);
        mem2proc_tag = 4'd0;
        mem2proc_data = '0;
        #1;
        check("fill_wr_mem", dc_wr_en_mem, 1);
        check("fill_wr_data", dc_wr_data, 64'h55);
        check("fill_wr_idx", dc_wr_idx, 0);
        check("fill_wr_tag", dc_wr_tag, 4);
        check("fill_resp_v", ld_resp_valid, 1);
        check("fill_resp_d", ld_resp_data, 64'h55);
        check("fill_st_ready", lsq_st_ready, 0);
        @(negedge clock);
        #1;
        check("post_ld_ready", lsq_ld_ready, 1);
        check("post_wr_mem", dc_wr_en_mem, 0);

        // five stores against a stalled bus, then in-order drain
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            lsq_st_valid = 1'b1;
            lsq_st_addr = 32'h400 + 32'(8 * i);
            lsq_st_data = 32'h10 + 32'(i);
            lsq_st_size = 3'd2;
            #1;
            check("fill_sb_ready", lsq_st_ready, (i < 4) ? 1 : 0);
            check("fill_sb_wr_lsq", dc_wr_en_lsq, (i < 4) ? 1 : 0);
            check("fill_sb_cmd", proc2mem_command, (i == 0) ? 0 : 2);
        end
        for (int j = 0; j < 4; j++) begin
            @(negedge clock);
            lsq_st_valid = 1'b0;
            mem2proc_response = 4'd1;
            #1;
            check("drain_cmd", proc2mem_command, 2);
            check("drain_addr", proc2mem_addr, 32'h400 + 32'(8 * j));
            check("drain_data", proc2mem_data, 64'h10 + 64'(j));
            check("drain_size", proc2mem_size, 2);
        end
        @(negedge clock);
        mem2proc_response = 4'd0;
        #1;
        check("drain_empty", proc2mem_command, 0);

        // queued store goes out before the miss to the same line
        @(negedge clock);
        lsq_st_valid = 1'b1;
        lsq_st_addr = 32'h300;
        lsq_st_data = 32'h77;
        lsq_st_size = 3'd2;
        @(negedge clock);
        lsq_st_valid = 1'b0;
        lsq_ld_valid = 1'b1;
        lsq_ld_addr = 32'h300;
        #1;
        check("ord_cmd_idle", proc2mem_command, 2);
        @(negedge clock);
        lsq_ld_valid = 1'b0;
        mem2proc_response = 4'd1;
        #1;
        check("ord_store_first", proc2mem_command, 2);
        check("ord_store_addr", proc2mem_addr, 32'h300);
        @(negedge clock);
        #1;
        check("ord_load_next", proc2mem_command, 1);
        check("ord_load_addr", proc2mem_addr, 32'h300);
        @(negedge clock);
        mem2proc_response = 4'd0;
        mem2proc_tag = 4'd1;
        mem2proc_data = 64'h99;

        // store stalls in the fill cycle, then writes the next cycle
        @(negedge clock);
        mem2proc_tag = 4'd0;
        lsq_st_valid = 1'b1;
        lsq_st_addr = 32'h30C;
        lsq_st_data = 32'h42;
        lsq_st_size = 3'd1;
        #1;
        check("ord_fill_d", ld_resp_data, 64'h99);
        check("conf_st_ready", lsq_st_ready, 0);
        check("conf_wr_lsq", dc_wr_en_lsq, 0);
        check("conf_wr_mem", dc_wr_en_mem, 1);
        @(negedge clock);
        #1;
        check("conf2_st_ready", lsq_st_ready, 1);
        check("conf2_wr_lsq", dc_wr_en_lsq, 1);
        check("conf2_size", dc_size, 1);
        check("conf2_offset", dc_offset, 1);
        check("conf2_wr_data", dc_wr_data, 64'h42);
        @(negedge clock);
        lsq_st_valid = 1'b0;
        mem2proc_response = 4'd1;
        #1;
        check("conf_drain_addr", proc2mem_addr, 32'h30C);
        check("conf_drain_size", proc2mem_size, 1);

        // reset abandons an outstanding miss
        @(negedge clock);
        mem2proc_response = 4'd0;
        lsq_ld_valid = 1'b1;
        lsq_ld_addr = 32'h500;
        @(negedge clock);
        lsq_ld_valid = 1'b0;
        mem2proc_response = 4'd2;
        @(negedge clock);
        mem2proc_response = 4'd0;
        #1;
        check("rw_in_wait", lsq_ld_ready, 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        mem2proc_tag = 4'd2;
        mem2proc_data = 64'h1234;
        #1;
        check("rw_ld_ready", lsq_ld_ready, 1);
        check("rw_resp_v", ld_resp_valid, 0);
        @(negedge clock);
        mem2proc_tag = 4'd0;
        #1;
        check("rw_no_fill", dc_wr_en_mem, 0);
        check("rw_no_resp", ld_resp_valid, 0);
        check("rw_ld_ready2", lsq_ld_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
